// File: rtl/wb_regfile_pkg.sv
// Shared constants for the writeback register file: the wb control bit positions,
// the default widths and the hard-wired zero register index.
// No logic and no latency; nothing in this file is clocked or applies backpressure.
package wb_regfile_pkg;

    // Bit positions inside the 2-bit writeback control field from MEM/WB
    localparam int WB_REGWRITE_BIT = 1;
    localparam int WB_MEMTOREG_BIT = 0;

    // Default datapath and address widths (32 x 32-bit registers)
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    // Index of the hard-wired zero register
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/wb_regfile_wb_select.sv
// Writeback source mux: picks load data or the ALU result as the value to write back.
// Latency: combinational, zero cycles.
// Backpressure: none; the output follows the inputs every cycle.
//
// Ports:
//   wb            in  2       writeback control (only the MemtoReg bit is used here)
//   alu_result    in  DATA_W  ALU result
//   mem_read_data in  DATA_W  load data
//   wb_data       out DATA_W  selected writeback value
module wb_select
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [1:0]        wb,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic [DATA_W-1:0] wb_data
);

    assign wb_data = wb[WB_MEMTOREG_BIT] ? mem_read_data : alu_result;

endmodule

// File: rtl/wb_regfile.sv
// Pipeline register file with writeback-source select, two combinational read ports and a commit counter.
// Latency: a write lands at the rising edge; reads are combinational; with the bypass enabled, the value being written appears on the read ports in its own cycle.
// Backpressure: none; every qualifying write commits, and any read-after-write hazard stall belongs to the hazard unit.
//
// Optional feature: define WB_REGFILE_BYPASS_EN to forward the value being written onto the read ports in
// the same cycle. With the macro undefined, reads return the value the array held before the edge.
//
// Ports:
//   clk           in  1       rising-edge clock
//   rst           in  1       synchronous active-high reset (clears array and counter)
//   wb            in  2       bit1 RegWrite, bit0 MemtoReg
//   alu_result    in  DATA_W  ALU result from MEM/WB
//   mem_read_data in  DATA_W  load data from MEM/WB
//   rd_addr       in  ADDR_W  destination register
//   rs_addr       in  ADDR_W  read port A address
//   rt_addr       in  ADDR_W  read port B address
//   rs_data       out DATA_W  read port A data
//   rt_data       out DATA_W  read port B data
//   wb_data       out DATA_W  selected writeback value (for EX forwarding)
//   wb_count      out 32      committed-write counter
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        wb,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data,
    output logic [31:0]       wb_count
);

    localparam int                NUM_REGS = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [31:0]       r_count;

    logic [DATA_W-1:0] w_wb_data;
    logic              w_commit;

    wb_select #(
        .DATA_W (DATA_W)
    ) u_wb_select (
        .wb            (wb),
        .alu_result    (alu_result),
        .mem_read_data (mem_read_data),
        .wb_data       (w_wb_data)
    );

    // A write only commits with RegWrite set, outside reset and to a non-zero
    // register. Gating the enable (not the data) keeps an undefined writeback
    // value away from the array whenever RegWrite is low.
    assign w_commit = wb[WB_REGWRITE_BIT] && (rd_addr != ZERO_IDX) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_count <= '0;
        end else if (w_commit) begin
            r_regs[rd_addr] <= w_wb_data;
            r_count         <= r_count + 32'd1;
        end
    end

    // Register 0 is forced to zero at the read port, so its storage never needs
    // to be trusted. w_commit already excludes reset and register 0, so it also
    // qualifies the bypass.
    always_comb begin
        rs_data = (rs_addr == ZERO_IDX) ? '0 : r_regs[rs_addr];
        rt_data = (rt_addr == ZERO_IDX) ? '0 : r_regs[rt_addr];
`ifdef WB_REGFILE_BYPASS_EN
        if (w_commit && (rs_addr == rd_addr)) begin
            rs_data = w_wb_data;
        end
        if (w_commit && (rt_addr == rd_addr)) begin
            rt_data = w_wb_data;
        end
`endif
    end

    assign wb_data  = w_wb_data;
    assign wb_count = r_count;

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    wb;
    logic [DW-1:0] alu_result;
    logic [DW-1:0] mem_read_data;
    logic [AW-1:0] rd_addr;
    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] wb_data;
    logic [31:0]   wb_count;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference state: the contents of the register file and the commit count
    logic [DW-1:0] m_regs [32];
    logic [31:0]   m_cnt;

    wb_regfile #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .wb            (wb),
        .alu_result    (alu_result),
        .mem_read_data (mem_read_data),
        .rd_addr       (rd_addr),
        .rs_addr       (rs_addr),
        .rt_addr       (rt_addr),
        .rs_data       (rs_data),
        .rt_data       (rt_data),
        .wb_data       (wb_data),
        .wb_count      (wb_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] m_wbd();
        return wb[0] ? mem_read_data : alu_result;
    endfunction

    function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
`ifdef WB_REGFILE_BYPASS_EN
        if (!rst && wb[1] && rd_addr != 0 && a == rd_addr) return m_wbd();
`endif
        return m_regs[a];
    endfunction

    // Reference update at each rising edge
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) m_regs[i] = '0;
            m_cnt = 32'd0;
        end else if (wb[1] && rd_addr != 0) begin
            m_regs[rd_addr] = m_wbd();
            m_cnt = m_cnt + 32'd1;
        end
    end

    // Per-cycle comparison against the reference, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("wb_data",  wb_data,  m_wbd());
            chk("rs_data",  rs_data,  m_read(rs_addr));
            chk("rt_data",  rt_data,  m_read(rt_addr));
            chk("wb_count", wb_count, m_cnt);
        end
    end

    task automatic drive(input logic r, input logic [1:0] w, input logic [AW-1:0] rd,
                         input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input logic [DW-1:0] alu, input logic [DW-1:0] mem);
        @(posedge clk);
        #1;
        rst = r; wb = w; rd_addr = rd; rs_addr = rs; rt_addr = rt;
        alu_result = alu; mem_read_data = mem;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d expected done", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] exp7;
        rst = 1'b1; wb = 2'b00; rd_addr = '0; rs_addr = '0; rt_addr = '0;
        alu_result = '0; mem_read_data = '0;
        m_cnt = 32'd0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;

        // Two reset cycles
        @(posedge clk);
        #1 chk_en = 1'b1;
        drive(1'b1, 2'b00, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);

        // All 32 addresses read 0 after reset
        for (int a = 0; a < 32; a++) begin
            drive(1'b0, 2'b00, 5'd0, 5'(a), 5'(31 - a), 32'h0, 32'h0);
            @(negedge clk);
            chk("reset_rs", rs_data, 32'h0);
            chk("reset_rt", rt_data, 32'h0);
        end
        chk("reset_cnt", wb_count, 32'h0);

        // ALU writeback to r5, read back next cycle
        drive(1'b0, 2'b10, 5'd5, 5'd0, 5'd0, 32'h1234, 32'h5678);
        @(negedge clk);
        chk("sel_alu", wb_data, 32'h1234);
        drive(1'b0, 2'b00, 5'd0, 5'd5, 5'd0, 32'h0, 32'h0);
        @(negedge clk);
        chk("r5_read", rs_data, 32'h1234);
        chk("r5_cnt", wb_count, 32'd1);

        // Load writeback to r0 is discarded
        drive(1'b0, 2'b11, 5'd0, 5'd0, 5'd0, 32'h0, 32'hFFFF);
        @(negedge clk);
        chk("sel_mem", wb_data, 32'hFFFF);
        drive(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
        @(negedge clk);
        chk("r0_read", rs_data, 32'h0);
        chk("r0_cnt", wb_count, 32'd1);

        // Same-cycle read of the register being written
        drive(1'b0, 2'b10, 5'd7, 5'd0, 5'd0, 32'h1111, 32'h0);
        drive(1'b0, 2'b11, 5'd7, 5'd7, 5'd7, 32'h0, 32'hABCD);
        @(negedge clk);
`ifdef WB_REGFILE_BYPASS_EN
        exp7 = 32'hABCD;
`else
        exp7 = 32'h1111;
`endif
        chk("hazard_rs", rs_data, exp7);
        chk("hazard_rt", rt_data, exp7);
        drive(1'b0, 2'b00, 5'd0, 5'd7, 5'd5, 32'h0, 32'h0);
        @(negedge clk);
        chk("r7_after", rs_data, 32'hABCD);
        chk("r7_cnt", wb_count, 32'd3);

        // Reset wins over a simultaneous write
        drive(1'b1, 2'b10, 5'd3, 5'd3, 5'd7, 32'h5555, 32'h0);
        @(negedge clk);
        chk("rst_nobyp", rs_data, 32'h0);
        drive(1'b0, 2'b00, 5'd0, 5'd3, 5'd7, 32'h0, 32'h0);
        @(negedge clk);
        chk("rst_r3", rs_data, 32'h0);
        chk("rst_r7", rt_data, 32'h0);
        chk("rst_cnt", wb_count, 32'h0);

        // First write immediately after reset deasserts
        drive(1'b1, 2'b00, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
        drive(1'b0, 2'b10, 5'd9, 5'd0, 5'd0, 32'h99, 32'h0);
        drive(1'b0, 2'b00, 5'd0, 5'd9, 5'd0, 32'h0, 32'h0);
        @(negedge clk);
        chk("post_rst_r9", rs_data, 32'h99);
        chk("post_rst_cnt", wb_count, 32'd1);

        // Counter wrap: preload near the top, then one more commit
        @(posedge clk);
        #1;
        force dut.r_count = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_count;
        @(negedge clk);
        chk("cnt_preload", wb_count, 32'hFFFF_FFFF);
        drive(1'b0, 2'b10, 5'd4, 5'd0, 5'd0, 32'h44, 32'h0);
        drive(1'b0, 2'b00, 5'd0, 5'd4, 5'd0, 32'h0, 32'h0);
        @(negedge clk);
        chk("cnt_wrap", wb_count, 32'h0);
        chk("wrap_r4", rs_data, 32'h44);

        // Randomized traffic; addresses biased so hazards and r0 occur often
        for (int n = 0; n < 2000; n++) begin
            logic [AW-1:0] rd, rs, rt;
            rd = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            rs = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom);
            rt = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom);
            drive(($urandom_range(0, 63) == 0), 2'($urandom), rd, rs, rt, $urandom, $urandom);
        end

        drive(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
